cmplx_exec_ctrl: RTL

- Initiator/controller for the complex register bank interface.
- Accepts one complex instruction at a time and drives the bank's read port (sel/cnst/enrreg).
- Captures the registered operands, computes a complex result, then drives the bank's write port (regwen/selwreg/endwreg/inA).
- Sits between the instruction source and the 16x64 complex register bank. Word format: [63:32] real, [31:0] imaginary, signed two's complement.

---
 rtl/cmplx_exec_ctrl_pkg.sv | 45 ++++
 rtl/cmplx_exec_ctrl_if.sv | 54 +++++
 rtl/cmplx_exec_ctrl_mul_seq.sv | 80 ++++++++
 rtl/cmplx_exec_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cmplx_exec_ctrl_pkg.sv
// Shared widths, opcodes, bank write modes, FSM codes and the
// saturation helper for the complex execution controller.
package cmplx_pkg;

  localparam int DW_DEF  = 32;
  localparam int RIW_DEF = 4;
  localparam int AW      = 2 * DW_DEF;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_CONJ = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_MOVR = 3'b101;
  localparam logic [2:0] OP_MOVI = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [1:0] EW_BOTH = 2'b00;
  localparam logic [1:0] EW_REAL = 2'b10;
  localparam logic [1:0] EW_IMAG = 2'b01;
  localparam logic [1:0] EW_SWAP = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;

  // clamp a wide signed value into the signed w-bit range
  function automatic logic [AW-1:0] sat(
    input logic signed [AW-1:0] v,
    input int w
  );
    logic signed [AW-1:0] one;
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] lo;
    one = {{(AW-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cmplx_exec_ctrl_if.sv
// Instruction handshake plus register bank read/write port bundle.
// master = controller side, slave = instruction source and bank.
interface cmplx_exec_ctrl_if
  import cmplx_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RIW = RIW_DEF
) ();

  logic            instr_valid;
  logic            instr_ready;
  logic [2:0]      instr_op;
  logic [RIW-1:0]  instr_dst;
  logic [RIW-1:0]  instr_srca;
  logic [RIW-1:0]  instr_srcb;
  logic            instr_cnsta;
  logic            instr_cnstb;
  logic            done;
  logic [2*DW-1:0] bank_outA;
  logic [2*DW-1:0] bank_outB;
  logic [RIW-1:0]  seloutA;
  logic [RIW-1:0]  seloutB;
  logic            cnstA;
  logic            cnstB;
  logic            enrregA;
  logic            enrregB;
  logic            regwen;
  logic [RIW-1:0]  selwreg;
  logic [1:0]      endwreg;
  logic [2*DW-1:0] inA;

  modport master (
    input  instr_valid, instr_op, instr_dst,
    input  instr_srca, instr_srcb,
    input  instr_cnsta, instr_cnstb,
    input  bank_outA, bank_outB,
    output instr_ready, done,
    output seloutA, seloutB, cnstA, cnstB,
    output enrregA, enrregB,
    output regwen, selwreg, endwreg, inA
  );

  modport slave (
    output instr_valid, instr_op, instr_dst,
    output instr_srca, instr_srcb,
    output instr_cnsta, instr_cnstb,
    output bank_outA, bank_outB,
    input  instr_ready, done,
    input  seloutA, seloutB, cnstA, cnstB,
    input  enrregA, enrregB,
    input  regwen, selwreg, endwreg, inA
  );

endinterface

// File: rtl/cmplx_exec_ctrl_mul_seq.sv
// Sequential complex multiplier: one shared DWxDW product per cycle,
// order ArBr, AiBi, ArBi, AiBr; final imag sum is presented on o_done.
module cmplx_mul_seq
  import cmplx_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [2*DW-1:0]        i_a,
  input  logic [2*DW-1:0]        i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic signed [2*DW-1:0] o_re,
  output logic signed [2*DW-1:0] o_im
);

  logic                   r_busy;
  logic [1:0]             r_step;
  logic [1:0]             w_step;
  logic [DW-1:0]          w_x;
  logic [DW-1:0]          w_y;
  logic signed [2*DW-1:0] w_p;
  logic signed [2*DW-1:0] r_accr;
  logic signed [2*DW-1:0] r_acci;

  assign w_step = r_busy ? r_step : 2'd0;

  always_comb begin
    w_x = i_a[2*DW-1:DW];
    w_y = i_b[2*DW-1:DW];
    unique case (w_step)
      2'd0: begin
        w_x = i_a[2*DW-1:DW];
        w_y = i_b[2*DW-1:DW];
      end
      2'd1: begin
        w_x = i_a[DW-1:0];
        w_y = i_b[DW-1:0];
      end
      2'd2: begin
        w_x = i_a[2*DW-1:DW];
        w_y = i_b[DW-1:0];
      end
      default: begin
        w_x = i_a[DW-1:0];
        w_y = i_b[2*DW-1:DW];
      end
    endcase
  end

  // sign-extended operands: low 2*DW bits equal the signed product
  assign w_p = {{DW{w_x[DW-1]}}, w_x}
             * {{DW{w_y[DW-1]}}, w_y};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_step <= 2'd0;
      r_accr <= '0;
      r_acci <= '0;
    end else if (i_start || r_busy) begin
      r_step <= w_step + 2'd1;
      r_busy <= (w_step != 2'd3);
      unique case (w_step)
        2'd0:    r_accr <= w_p;
        2'd1:    r_accr <= r_accr - w_p;
        2'd2:    r_acci <= w_p;
        default: r_acci <= r_acci + w_p;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_step == 2'd3);
  assign o_re   = r_accr;
  assign o_im   = r_acci + w_p;

endmodule

// File: rtl/cmplx_exec_ctrl.sv
// Complex instruction controller for the 16x64 register bank.
// Define CMPLX_SAT_EN to saturate ADD/SUB/MUL/CONJ results.
module cmplx_exec_ctrl
  import cmplx_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RIW = RIW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  cmplx_exec_ctrl_if.master bus
);

  logic [2:0]             r_state;
  logic [2:0]             r_op;
  logic [RIW-1:0]         r_dst;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_enA;
  logic                   r_enB;
  logic                   r_cA;
  logic                   r_cB;
  logic [RIW-1:0]         r_selA;
  logic [RIW-1:0]         r_selB;
  logic                   r_wen;
  logic [RIW-1:0]         r_selw;
  logic [1:0]             r_ew;
  logic [2*DW-1:0]        r_inA;
  logic [2*DW-1:0]        r_opa;
  logic [2*DW-1:0]        r_opb;

  logic                   w_mstart;
  logic                   w_mbusy;
  logic                   w_mdone;
  logic signed [2*DW-1:0] w_mre;
  logic signed [2*DW-1:0] w_mim;
  logic signed [2*DW-1:0] w_ar;
  logic signed [2*DW-1:0] w_ai;
  logic signed [2*DW-1:0] w_br;
  logic signed [2*DW-1:0] w_bi;
  logic [2*DW-1:0]        w_wdata;
  logic [1:0]             w_ew;

  function automatic logic [DW-1:0] fit(
    input logic signed [2*DW-1:0] v
  );
`ifdef CMPLX_SAT_EN
    logic [AW-1:0] s;
    s = sat(AW'(v), DW);
    return s[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  assign w_ar = {{DW{r_opa[2*DW-1]}}, r_opa[2*DW-1:DW]};
  assign w_ai = {{DW{r_opa[DW-1]}}, r_opa[DW-1:0]};
  assign w_br = {{DW{r_opb[2*DW-1]}}, r_opb[2*DW-1:DW]};
  assign w_bi = {{DW{r_opb[DW-1]}}, r_opb[DW-1:0]};

  assign w_mstart = (r_state == ST_EXEC)
                 && (r_op == OP_MUL) && !w_mbusy;

  cmplx_mul_seq #(.DW(DW)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_mstart),
    .i_a     (r_opa),
    .i_b     (r_opb),
    .o_busy  (w_mbusy),
    .o_done  (w_mdone),
    .o_re    (w_mre),
    .o_im    (w_mim)
  );

  always_comb begin
    w_wdata = '0;
    w_ew    = EW_BOTH;
    unique case (r_op)
      OP_ADD:  w_wdata = {fit(w_ar + w_br), fit(w_ai + w_bi)};
      OP_SUB:  w_wdata = {fit(w_ar - w_br), fit(w_ai - w_bi)};
      OP_MUL:  w_wdata = {fit(w_mre), fit(w_mim)};
      OP_CONJ: w_wdata = {fit(w_ar), fit(-w_ai)};
      OP_SWAP: begin
        w_wdata = r_opa;
        w_ew    = EW_SWAP;
      end
      OP_MOVR: begin
        w_wdata = r_opa;
        w_ew    = EW_REAL;
      end
      OP_MOVI: begin
        w_wdata = r_opa;
        w_ew    = EW_IMAG;
      end
      default: w_wdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_dst   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_enA   <= 1'b0;
      r_enB   <= 1'b0;
      r_cA    <= 1'b0;
      r_cB    <= 1'b0;
      r_selA  <= '0;
      r_selB  <= '0;
      r_wen   <= 1'b0;
      r_selw  <= '0;
      r_ew    <= '0;
      r_inA   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.instr_valid && r_ready) begin
            r_ready <= 1'b0;
            r_op    <= bus.instr_op;
            r_dst   <= bus.instr_dst;
            r_selA  <= bus.instr_srca;
            r_selB  <= bus.instr_srcb;
            r_cA    <= bus.instr_cnsta;
            r_cB    <= bus.instr_cnstb;
            r_enA   <= 1'b1;
            r_enB   <= 1'b1;
            r_state <= ST_READ;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_READ: begin
          r_enA   <= 1'b0;
          r_enB   <= 1'b0;
          r_selA  <= '0;
          r_selB  <= '0;
          r_cA    <= 1'b0;
          r_cB    <= 1'b0;
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_opa   <= bus.bank_outA;
          r_opb   <= bus.bank_outB;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if ((r_op != OP_MUL) || w_mdone) begin
            r_wen   <= (r_op != OP_NOP);
            r_selw  <= r_dst;
            r_ew    <= w_ew;
            r_inA   <= w_wdata;
            r_done  <= 1'b1;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_wen   <= 1'b0;
          r_done  <= 1'b0;
          r_selw  <= '0;
          r_ew    <= '0;
          r_inA   <= '0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.done        = r_done;
  assign bus.seloutA     = r_selA;
  assign bus.seloutB     = r_selB;
  assign bus.cnstA       = r_cA;
  assign bus.cnstB       = r_cB;
  assign bus.enrregA     = r_enA;
  assign bus.enrregB     = r_enB;
  assign bus.regwen      = r_wen;
  assign bus.selwreg     = r_selw;
  assign bus.endwreg     = r_ew;
  assign bus.inA         = r_inA;

endmodule
